// File: rtl/imem_port_arbiter_pkg.sv
// imem_port_arbiter_pkg
//   Shared constants and types for the instruction-memory port arbiter.
//   ADDR_WIDTH/DATA_WIDTH/DATA_BYTES : default memory geometry
//   IMEM_MAX_LOAD_RUN                : default loader burst limit while fetch waits
//   rd_owner_e                       : which requester owns the read in flight
package imem_port_arbiter_pkg;

    localparam int ADDR_WIDTH        = 10;
    localparam int DATA_WIDTH        = 32;
    localparam int DATA_BYTES        = DATA_WIDTH / 8;
    localparam int IMEM_MAX_LOAD_RUN = 4;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_LOAD  = 2'd2
    } rd_owner_e;

endpackage

// File: rtl/imem_port_arbiter_if.sv
// imem_port_arbiter_if
//   Bundles the fetch port, loader port and memory-side signals of the
//   instruction-memory arbiter.
//   slave  : the arbiter (takes requests + mem read data, drives grants/returns/mem ctrl)
//   master : the surrounding requesters and memory (the other side)
interface imem_port_arbiter_if #(
    parameter int ADDR_WIDTH = imem_port_arbiter_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = imem_port_arbiter_pkg::DATA_WIDTH,
    parameter int DATA_BYTES = imem_port_arbiter_pkg::DATA_BYTES
);
    // fetch port
    logic                  f_req_i;
    logic [ADDR_WIDTH-1:0] f_addr_i;
    logic                  f_gnt_o;
    logic                  f_rvalid_o;
    logic [DATA_WIDTH-1:0] f_rdata_o;
    // loader port
    logic                  l_req_i;
    logic                  l_we_i;
    logic [ADDR_WIDTH-1:0] l_addr_i;
    logic [DATA_WIDTH-1:0] l_wdata_i;
    logic [DATA_BYTES-1:0] l_be_i;
    logic                  l_gnt_o;
    logic                  l_rvalid_o;
    logic [DATA_WIDTH-1:0] l_rdata_o;
    // memory side
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic [DATA_BYTES-1:0] mem_wen_o;
    logic [DATA_WIDTH-1:0] mem_rdata_i;

    modport slave (
        input  f_req_i, f_addr_i,
        output f_gnt_o, f_rvalid_o, f_rdata_o,
        input  l_req_i, l_we_i, l_addr_i, l_wdata_i, l_be_i,
        output l_gnt_o, l_rvalid_o, l_rdata_o,
        output mem_addr_o, mem_wdata_o, mem_wen_o,
        input  mem_rdata_i
    );

    modport master (
        output f_req_i, f_addr_i,
        input  f_gnt_o, f_rvalid_o, f_rdata_o,
        output l_req_i, l_we_i, l_addr_i, l_wdata_i, l_be_i,
        input  l_gnt_o, l_rvalid_o, l_rdata_o,
        input  mem_addr_o, mem_wdata_o, mem_wen_o,
        output mem_rdata_i
    );

endinterface

// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter
//   Shares a single-port, one-cycle-latency instruction memory between the
//   fetch stage (read only) and the loader/debug port (read/write).
//   Grants are combinational; read data is steered back to the requester
//   that owned the read issued in the previous cycle.
//   Ports:
//     clk  : clock
//     rst  : asynchronous, active-low reset
//     bus  : imem_port_arbiter_if.slave (fetch, loader and memory signals)
//   Build option:
//     IMEM_ARB_STARVE_GUARD_EN - after MAX_LOAD_RUN consecutive loader grants
//     with fetch waiting, fetch gets the next slot. Undefined: strict loader
//     priority, no run counter.
module imem_port_arbiter #(
    parameter int ADDR_WIDTH   = imem_port_arbiter_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH   = imem_port_arbiter_pkg::DATA_WIDTH,
    parameter int DATA_BYTES   = imem_port_arbiter_pkg::DATA_BYTES,
    parameter int MAX_LOAD_RUN = imem_port_arbiter_pkg::IMEM_MAX_LOAD_RUN
) (
    input  logic                 clk,
    input  logic                 rst,
    imem_port_arbiter_if.slave   bus
);
    import imem_port_arbiter_pkg::*;

    logic                  f_gnt, l_gnt;
    logic                  force_f;   // starvation guard hands the slot to fetch
    rd_owner_e             owner_q, owner_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

`ifdef IMEM_ARB_STARVE_GUARD_EN
    localparam int RUN_W = $clog2(MAX_LOAD_RUN + 1);
    logic [RUN_W-1:0] run_q, run_d;

    assign force_f = bus.f_req_i && (run_q == RUN_W'(MAX_LOAD_RUN));

    // Counts loader wins only while fetch is actually waiting.
    always_comb begin
        run_d = run_q;
        if (!bus.f_req_i || f_gnt) run_d = '0;
        else if (l_gnt)            run_d = run_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) run_q <= '0;
        else      run_q <= run_d;
    end
`else
    assign force_f = 1'b0;
`endif

    // Gated by rst so nothing is granted (and nothing written) in reset.
    assign l_gnt = rst && bus.l_req_i && !force_f;
    assign f_gnt = rst && bus.f_req_i && (!bus.l_req_i || force_f);

    assign bus.f_gnt_o = f_gnt;
    assign bus.l_gnt_o = l_gnt;

    // Address holds its last granted value when idle so the memory sees
    // no spurious address toggles.
    always_comb begin
        addr_d = addr_q;
        if (l_gnt)      addr_d = bus.l_addr_i;
        else if (f_gnt) addr_d = bus.f_addr_i;
    end

    assign bus.mem_addr_o  = addr_d;
    assign bus.mem_wdata_o = bus.l_wdata_i;
    assign bus.mem_wen_o   = (l_gnt && bus.l_we_i) ? bus.l_be_i : '0;

    always_comb begin
        owner_d = OWN_NONE;
        if (f_gnt)                     owner_d = OWN_FETCH;
        else if (l_gnt && !bus.l_we_i) owner_d = OWN_LOAD;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q <= OWN_NONE;
            addr_q  <= '0;
        end else begin
            owner_q <= owner_d;
            addr_q  <= addr_d;
        end
    end

    // Read data is zeroed unless this requester owns the returning read.
    assign bus.f_rvalid_o = (owner_q == OWN_FETCH);
    assign bus.l_rvalid_o = (owner_q == OWN_LOAD);
    assign bus.f_rdata_o  = bus.f_rvalid_o ? bus.mem_rdata_i : '0;
    assign bus.l_rdata_o  = bus.l_rvalid_o ? bus.mem_rdata_i : '0;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb_imem_port_arbiter
//   Directed bench for imem_port_arbiter with a behavioural one-cycle-latency
//   byte-enabled memory. Inputs change on the falling edge; outputs are
//   sampled 1 ns later. Starvation expectations follow
//   IMEM_ARB_STARVE_GUARD_EN.
module tb_imem_port_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    imem_port_arbiter_if bus ();

    imem_port_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural memory: 256 words, preloaded on the first clock edge.
    logic [31:0] mem [0:255];
    logic        mem_loaded = 1'b0;

    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            mem[0]  <= 32'h0000_0013;
            mem[1]  <= 32'h0000_0093;
            mem[2]  <= 32'h0000_0113;
            mem[3]  <= 32'h0000_0193;
            mem[8]  <= 32'hA5A5_0008;
            mem[16] <= 32'h1122_3344;
            mem_loaded <= 1'b1;
        end else begin
            for (int b = 0; b < 4; b++)
                if (bus.mem_wen_o[b]) mem[bus.mem_addr_o[9:2]][b*8 +: 8] <= bus.mem_wdata_o[b*8 +: 8];
        end
        bus.mem_rdata_i <= mem[bus.mem_addr_o[9:2]];
    end

    task automatic idle_inputs();
        bus.f_req_i   = 1'b0;
        bus.f_addr_i  = '0;
        bus.l_req_i   = 1'b0;
        bus.l_we_i    = 1'b0;
        bus.l_addr_i  = '0;
        bus.l_wdata_i = '0;
        bus.l_be_i    = '0;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.f_req_i  = 1'b1;
        bus.f_addr_i = 10'h000;
        for (int i = 0; i < 3; i++) begin
            step(); #1;
            n_vec++; if (bus.f_gnt_o !== 1'b0) begin n_err++; $display("FAIL rst_fgnt: got %b want 0", bus.f_gnt_o); end
            n_vec++; if (bus.f_rvalid_o !== 1'b0) begin n_err++; $display("FAIL rst_frvalid: got %b want 0", bus.f_rvalid_o); end
            n_vec++; if (bus.mem_wen_o !== 4'h0) begin n_err++; $display("FAIL rst_wen: got %h want 0", bus.mem_wen_o); end
        end
        n_vec++; if (bus.mem_addr_o !== 10'h0) begin n_err++; $display("FAIL rst_addr: got %h want 0", bus.mem_addr_o); end
        n_vec++; if (bus.f_rdata_o !== 32'h0) begin n_err++; $display("FAIL rst_frdata: got %h want 0", bus.f_rdata_o); end
        step(); rst = 1'b1; #1;
        n_vec++; if (bus.f_gnt_o !== 1'b1) begin n_err++; $display("FAIL rel_fgnt: got %b want 1", bus.f_gnt_o); end
        step(); bus.f_req_i = 1'b0; #1;
        n_vec++; if (bus.f_rvalid_o !== 1'b1) begin n_err++; $display("FAIL rel_frvalid: got %b want 1", bus.f_rvalid_o); end
        n_vec++; if (bus.f_rdata_o !== 32'h13) begin n_err++; $display("FAIL rel_frdata: got %h want 13", bus.f_rdata_o); end
    endtask

    task automatic test_fetch_stream();
        logic [31:0] exp_d [0:3];
        exp_d[0] = 32'h13; exp_d[1] = 32'h93; exp_d[2] = 32'h113; exp_d[3] = 32'h193;
        for (int i = 0; i < 5; i++) begin
            step();
            bus.f_req_i  = (i < 4);
            bus.f_addr_i = 10'(i * 4);
            #1;
            if (i < 4) begin
                n_vec++; if (bus.f_gnt_o !== 1'b1) begin n_err++; $display("FAIL stream_gnt%0d: got %b want 1", i, bus.f_gnt_o); end
            end
            if (i > 0) begin
                n_vec++; if (bus.f_rvalid_o !== 1'b1) begin n_err++; $display("FAIL stream_rvalid%0d: got %b want 1", i, bus.f_rvalid_o); end
                n_vec++; if (bus.f_rdata_o !== exp_d[i-1]) begin n_err++; $display("FAIL stream_rdata%0d: got %h want %h", i, bus.f_rdata_o, exp_d[i-1]); end
            end
        end
        step(); #1;
        n_vec++; if (bus.f_rvalid_o !== 1'b0) begin n_err++; $display("FAIL stream_end: got %b want 0", bus.f_rvalid_o); end
    endtask

    task automatic test_contention();
        step();
        bus.f_req_i = 1'b1; bus.f_addr_i = 10'h004;
        bus.l_req_i = 1'b1; bus.l_we_i = 1'b0; bus.l_addr_i = 10'h020;
        #1;
        n_vec++; if ({bus.l_gnt_o, bus.f_gnt_o} !== 2'b10) begin n_err++; $display("FAIL cont_gnt: got %b want 10", {bus.l_gnt_o, bus.f_gnt_o}); end
        n_vec++; if (bus.mem_addr_o !== 10'h020) begin n_err++; $display("FAIL cont_addr: got %h want 020", bus.mem_addr_o); end
        step(); bus.l_req_i = 1'b0; #1;
        n_vec++; if (bus.l_rvalid_o !== 1'b1) begin n_err++; $display("FAIL cont_lrvalid: got %b want 1", bus.l_rvalid_o); end
        n_vec++; if (bus.l_rdata_o !== 32'hA5A5_0008) begin n_err++; $display("FAIL cont_lrdata: got %h want a5a50008", bus.l_rdata_o); end
        n_vec++; if (bus.f_rdata_o !== 32'h0) begin n_err++; $display("FAIL cont_frdata0: got %h want 0", bus.f_rdata_o); end
        n_vec++; if (bus.f_gnt_o !== 1'b1) begin n_err++; $display("FAIL cont_fgnt: got %b want 1", bus.f_gnt_o); end
        step(); bus.f_req_i = 1'b0; #1;
        n_vec++; if (bus.f_rvalid_o !== 1'b1 || bus.l_rvalid_o !== 1'b0) begin n_err++; $display("FAIL cont_frvalid: got f%b l%b want f1 l0", bus.f_rvalid_o, bus.l_rvalid_o); end
        n_vec++; if (bus.f_rdata_o !== 32'h93) begin n_err++; $display("FAIL cont_frdata: got %h want 93", bus.f_rdata_o); end
    endtask

    task automatic test_write_then_read();
        step();
        bus.l_req_i = 1'b1; bus.l_we_i = 1'b1; bus.l_addr_i = 10'h040;
        bus.l_wdata_i = 32'hDEAD_BEEF; bus.l_be_i = 4'b0011;
        #1;
        n_vec++; if (bus.l_gnt_o !== 1'b1) begin n_err++; $display("FAIL wr_gnt: got %b want 1", bus.l_gnt_o); end
        n_vec++; if (bus.mem_wen_o !== 4'b0011) begin n_err++; $display("FAIL wr_wen: got %b want 0011", bus.mem_wen_o); end
        n_vec++; if (bus.mem_wdata_o !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL wr_wdata: got %h want deadbeef", bus.mem_wdata_o); end
        step();
        bus.l_req_i = 1'b0;
        bus.f_req_i = 1'b1; bus.f_addr_i = 10'h040;
        #1;
        n_vec++; if (bus.f_gnt_o !== 1'b1) begin n_err++; $display("FAIL wr_fgnt: got %b want 1", bus.f_gnt_o); end
        n_vec++; if (bus.mem_wen_o !== 4'b0000) begin n_err++; $display("FAIL wr_wen_off: got %b want 0000", bus.mem_wen_o); end
        n_vec++; if (bus.l_rvalid_o !== 1'b0) begin n_err++; $display("FAIL wr_lrvalid: got %b want 0", bus.l_rvalid_o); end
        step(); bus.f_req_i = 1'b0; bus.l_we_i = 1'b0; bus.l_be_i = '0; #1;
        n_vec++; if (bus.f_rvalid_o !== 1'b1) begin n_err++; $display("FAIL wr_frvalid: got %b want 1", bus.f_rvalid_o); end
        n_vec++; if (bus.f_rdata_o !== 32'h1122_BEEF) begin n_err++; $display("FAIL wr_frdata: got %h want 1122beef", bus.f_rdata_o); end
        n_vec++; if (bus.l_rvalid_o !== 1'b0) begin n_err++; $display("FAIL wr_lrvalid2: got %b want 0", bus.l_rvalid_o); end
    endtask

    task automatic test_starvation();
        logic [1:0]  exp_g;
        logic [9:0]  exp_addr;
        exp_addr = 10'h0;
        step();
        bus.f_req_i = 1'b1; bus.f_addr_i = 10'h008;
        bus.l_req_i = 1'b1; bus.l_we_i = 1'b0; bus.l_addr_i = 10'h020;
        for (int i = 0; i < 10; i++) begin
            if (i != 0) step();
            #1;
`ifdef IMEM_ARB_STARVE_GUARD_EN
            exp_g = ((i % 5) == 4) ? 2'b01 : 2'b10;
`else
            exp_g = 2'b10;
`endif
            exp_addr = exp_g[0] ? 10'h008 : 10'h020;
            n_vec++; if ({bus.l_gnt_o, bus.f_gnt_o} !== exp_g) begin n_err++; $display("FAIL starve%0d: got l%b f%b want %b", i, bus.l_gnt_o, bus.f_gnt_o, exp_g); end
        end
        step(); idle_inputs(); #1;
        n_vec++; if (bus.mem_addr_o !== exp_addr) begin n_err++; $display("FAIL hold_addr: got %h want %h", bus.mem_addr_o, exp_addr); end
        n_vec++; if ({bus.f_gnt_o, bus.l_gnt_o, bus.mem_wen_o} !== 6'b0) begin n_err++; $display("FAIL idle_gnt: got %b want 0", {bus.f_gnt_o, bus.l_gnt_o, bus.mem_wen_o}); end
    endtask

    task automatic test_reset_mid_read();
        step();
        bus.f_req_i = 1'b1; bus.f_addr_i = 10'h00C;
        #1;
        n_vec++; if (bus.f_gnt_o !== 1'b1) begin n_err++; $display("FAIL mid_gnt: got %b want 1", bus.f_gnt_o); end
        @(posedge clk); #1;
        bus.f_req_i = 1'b0;
        rst = 1'b0; #1;
        n_vec++; if (bus.f_rvalid_o !== 1'b0 || bus.f_rdata_o !== 32'h0) begin n_err++; $display("FAIL mid_rst: got v%b d%h want v0 d0", bus.f_rvalid_o, bus.f_rdata_o); end
        n_vec++; if (bus.mem_addr_o !== 10'h0) begin n_err++; $display("FAIL mid_addr: got %h want 0", bus.mem_addr_o); end
        step(); step(); rst = 1'b1; #1;
        n_vec++; if (bus.f_rvalid_o !== 1'b0) begin n_err++; $display("FAIL mid_rel0: got %b want 0", bus.f_rvalid_o); end
        step(); #1;
        n_vec++; if (bus.f_rvalid_o !== 1'b0 || bus.l_rvalid_o !== 1'b0) begin n_err++; $display("FAIL mid_rel1: got f%b l%b want 0", bus.f_rvalid_o, bus.l_rvalid_o); end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_fetch_stream();
        test_contention();
        test_write_then_read();
        test_starvation();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/imem_port_arbiter.md
Name: imem_port_arbiter

Overview:
- Shares the single-port synchronous instruction memory between two requesters: the fetch stage (read-only) and a program loader/debug port (read/write).
- Sits between the requesters and the memory instance.
- Owns grant decisions, drives the memory write-enable, and routes the one-cycle-latency read data back to whichever requester issued the read.

Parameters:
- ADDR_WIDTH, 10: memory address width in bytes. Passed straight to the memory address port.
- DATA_WIDTH, 32: data word width.
- DATA_BYTES, 4: number of byte lanes. Equals DATA_WIDTH/8.
- MAX_LOAD_RUN, 4: maximum number of consecutive loader grants while fetch is waiting. Used only with the optional feature.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- f_req_i  in  1  fetch read request
- f_addr_i  in  ADDR_WIDTH  fetch byte address
- f_gnt_o  out  1  fetch request accepted this cycle
- f_rvalid_o  out  1  fetch read data valid
- f_rdata_o  out  DATA_WIDTH  fetch read data
- l_req_i  in  1  loader request
- l_we_i  in  1  loader write (1) / read (0)
- l_addr_i  in  ADDR_WIDTH  loader byte address
- l_wdata_i  in  DATA_WIDTH  loader write data
- l_be_i  in  DATA_BYTES  loader byte enables
- l_gnt_o  out  1  loader request accepted this cycle
- l_rvalid_o  out  1  loader read data valid
- l_rdata_o  out  DATA_WIDTH  loader read data
- mem_addr_o  out  ADDR_WIDTH  memory address
- mem_wdata_o  out  DATA_WIDTH  memory write data
- mem_wen_o  out  DATA_BYTES  memory byte write enables
- mem_rdata_i  in  DATA_WIDTH  memory read data, valid one cycle after the address

Behaviour:
- Grant is combinational, in the same cycle as the request.
  - At most one of f_gnt_o / l_gnt_o is high in any cycle.
  - A requester holds req/addr/data stable until granted.
- Default arbitration: loader has strict priority. fetch is granted only when l_req_i=0.
- mem_addr_o follows the granted requester's address.
  - With no grant, mem_addr_o holds the last granted address.
  - mem_wen_o=0 with no grant.
- mem_wen_o = l_be_i only when l_gnt_o=1 and l_we_i=1; otherwise 0.
- mem_wdata_o always equals l_wdata_i.
- Read-owner register rd_owner ∈ {NONE, FETCH, LOAD}, updated every cycle:
  - FETCH if f_gnt_o;
  - LOAD if l_gnt_o and !l_we_i;
  - else NONE.
- Read return timing:
  - Cycle N+1 after a read grant: f_rvalid_o=1 if rd_owner=FETCH; l_rvalid_o=1 if rd_owner=LOAD.
  - The matching rdata output carries mem_rdata_i.
  - Writes produce no rvalid.
- Back-to-back grants are allowed every cycle, giving throughput of 1 access/cycle.
  - Example: a read granted in cycle N returns in N+1 while a new access is granted in N+1.
- rdata outputs are 0 whenever the corresponding rvalid is 0. No X leakage.
- Reset, asynchronous, on rst=0:
  - rd_owner=NONE; all rvalid=0; all rdata=0; mem_wen_o=0; mem_addr_o=0; run counter=0.
  - Grants are forced to 0 while rst=0.
- Reset mid-operation: an outstanding read return is discarded (no rvalid after reset release).
- Fetch and loader requesting the same address in the same cycle: only the winner is served; the loser retries next cycle.
- Loader write followed by a fetch read to the same address in the next cycle: fetch sees the new data. The memory write completes at the clock edge.

Optional Feature:
- Macro: IMEM_ARB_STARVE_GUARD_EN.
- Defined:
  - A run counter (width clog2(MAX_LOAD_RUN+1)) increments on each loader grant made while f_req_i=1.
  - When the counter equals MAX_LOAD_RUN and f_req_i=1, fetch is granted next, even if l_req_i=1. The counter then clears.
  - The counter also clears on any fetch grant, or on any cycle with f_req_i=0.
- Not defined: strict loader priority, and no counter logic is synthesized.

Decomposition:
- Shared package core:
  - reuse ADDR_WIDTH, DATA_WIDTH, DATA_BYTES;
  - add enum rd_owner_e {OWN_NONE, OWN_FETCH, OWN_LOAD};
  - add constant IMEM_MAX_LOAD_RUN=4.
- No sub-module.
  - The grant logic and starvation counter stay in this module.
  - The memory instance stays outside, in the fetch stage's parent.

Test Plan:
- Reset: hold rst=0 with f_req_i=1 for 3 cycles -> f_gnt_o=0, f_rvalid_o=0, mem_wen_o=0. Release -> f_gnt_o=1 in the same cycle, f_rvalid_o=1 one cycle later.
- Fetch stream: f_req_i=1 at addresses 0,4,8,12 on consecutive cycles, memory preloaded 0x13,0x93,0x113,0x193 -> f_rdata_o returns those values in cycles 1..4, with rvalid high 4 cycles straight.
- Contention: f_req_i=1 and l_req_i=1 (read, addr 0x20) simultaneously -> l_gnt_o=1, f_gnt_o=0. Next cycle: l_rvalid_o=1, f_gnt_o=1.
- Write-then-read: loader writes 0xDEADBEEF with l_be_i=4'b0011 to addr 0x40 (old value 0x11223344); fetch reads 0x40 next cycle -> f_rdata_o=0x1122BEEF, and l_rvalid_o stays 0.
- Starvation (IMEM_ARB_STARVE_GUARD_EN defined, MAX_LOAD_RUN=4): loader and fetch both request continuously -> grant pattern L,L,L,L,F repeating. Without the macro -> L only.
- Reset mid-read: fetch granted in cycle N, rst=0 asserted before edge N+1 -> no f_rvalid_o after release until a new grant.
